// File: rtl/upcounter_ctrl_if.sv
// upcounter_ctrl_if
//   Groups the request/status and counter-facing signals of upcounter_ctrl.
//   master : request side plus the counter feedback (start, abort, hold,
//            use_preset, preset, wraps, q, c); observes the strobes/status.
//   slave  : the sequencer; drives clear, load, incr, d, busy, done,
//            wrap_cnt, err.
//   Parameters: W = counter width, NW = wrap-count width.
interface upcounter_ctrl_if #(
  parameter int W  = 4,
  parameter int NW = 4
);
  logic          start;
  logic          abort;
  logic          hold;
  logic          use_preset;
  logic [W-1:0]  preset;
  logic [NW-1:0] wraps;
  logic [W-1:0]  q;
  logic          c;
  logic          clear;
  logic          load;
  logic          incr;
  logic [W-1:0]  d;
  logic          busy;
  logic          done;
  logic [NW-1:0] wrap_cnt;
  logic          err;

  modport master (
    output start, abort, hold, use_preset, preset, wraps, q, c,
    input  clear, load, incr, d, busy, done, wrap_cnt, err
  );

  modport slave (
    input  start, abort, hold, use_preset, preset, wraps, q, c,
    output clear, load, incr, d, busy, done, wrap_cnt, err
  );
endinterface

// File: rtl/upcounter_ctrl.sv
// upcounter_ctrl
//   Sequencer in front of a W-bit loadable up-counter. On start it clears or
//   preset-loads the counter, increments it until the programmed number of
//   wrap-arounds has been observed on q, then pulses done.
//
// Ports
//   clk    : clock, rising edge
//   clr_n  : asynchronous active-low reset
//   io_ctl : upcounter_ctrl_if.slave (request inputs, counter feedback q/c,
//            counter strobes clear/load/incr/d, status busy/done/wrap_cnt/err)
//
// Optional feature: define UPCOUNTER_CTRL_CARRY_CHECK_EN to cross-check the
// counter carry c against predicted wraps (sticky err). Undefined: err = 0.
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | waiting for start, all strobes low
// CLR    | one-cycle counter clear
// LOAD   | one-cycle counter load of captured preset
// RUN    | incrementing (gated by hold), counting wraps
// DONE   | one-cycle completion pulse
module upcounter_ctrl #(
  parameter int W  = 4,
  parameter int NW = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  upcounter_ctrl_if.slave  io_ctl
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_LOAD = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [W-1:0]  r_preset;
  logic [NW-1:0] r_wraps;
  logic [NW-1:0] r_wrap_cnt;
  logic [NW-1:0] w_wrap_cnt_inc;
  logic          w_accept;
  logic          w_wrap;
  logic          w_clear;
  logic          w_load;
  logic          w_incr;
  logic          w_busy;
  logic          w_done;

  assign w_accept       = (r_state == S_IDLE) && io_ctl.start && !io_ctl.abort;
  // The counter wraps at the edge where an increment is issued at all-ones.
  assign w_wrap         = (r_state == S_RUN) && !io_ctl.hold && (io_ctl.q == '1);
  assign w_wrap_cnt_inc = r_wrap_cnt + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_load      = 1'b0;
    w_incr      = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = io_ctl.use_preset ? S_LOAD : S_CLR;
      end
      S_CLR: begin
        w_clear     = 1'b1;
        w_busy      = 1'b1;
        w_state_nxt = (r_wraps == '0) ? S_DONE : S_RUN;
      end
      S_LOAD: begin
        w_load      = 1'b1;
        w_busy      = 1'b1;
        w_state_nxt = (r_wraps == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        w_busy = 1'b1;
        w_incr = !io_ctl.hold;
        if (w_wrap && (w_wrap_cnt_inc == r_wraps)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Abort overrides every other transition out of a non-idle state.
    if ((r_state != S_IDLE) && io_ctl.abort) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state    <= S_IDLE;
      r_preset   <= '0;
      r_wraps    <= '0;
      r_wrap_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_preset   <= io_ctl.preset;
        r_wraps    <= io_ctl.wraps;
        r_wrap_cnt <= '0;
      end else if (w_wrap && !io_ctl.abort) begin
        r_wrap_cnt <= w_wrap_cnt_inc;
      end
    end
  end

  assign io_ctl.clear    = w_clear;
  assign io_ctl.load     = w_load;
  assign io_ctl.incr     = w_incr;
  assign io_ctl.busy     = w_busy;
  assign io_ctl.done     = w_done;
  assign io_ctl.d        = r_preset;
  assign io_ctl.wrap_cnt = r_wrap_cnt;

`ifdef UPCOUNTER_CTRL_CARRY_CHECK_EN
  logic r_wrap_d;
  logic r_err;

  // c is expected exactly one cycle after each predicted wrap edge; any
  // disagreement while in RUN/DONE is latched until reset or the next start.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_wrap_d <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_wrap_d <= w_wrap;
      if (w_accept) begin
        r_err <= 1'b0;
      end else if (((r_state == S_RUN) || (r_state == S_DONE)) &&
                   (r_wrap_d != io_ctl.c)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign io_ctl.err = r_err;
`else
  assign io_ctl.err = 1'b0;
`endif

endmodule
